// File: rtl/audio_pkg.sv
// Shared audio types for the codec front end.
//   AUDIO_W    : native sample width of the effect chain
//   sample_t   : signed audio sample as seen by the effect stages
//   rx_state_t : I2S receiver word-alignment states
package audio_pkg;

    localparam int AUDIO_W = 16;

    typedef logic signed [AUDIO_W-1:0] sample_t;

    typedef enum logic [1:0] {
        ALIGN,
        SKIP,
        SHIFT,
        HOLD
    } rx_state_t;

endpackage

// File: rtl/i2s_adc_rx_sync_edge.sv
// sync_edge: multi-flop synchroniser for an asynchronous 1-bit input,
// followed by a change detector on the synchronised level.
//   Clk    in   system clock
//   d_i    in   asynchronous input
//   q_o    out  synchronised level (STAGES flops behind the pin)
//   edge_o out  1 for one Clk when q_o differs from its previous value;
//               rise = edge_o & q_o, fall = edge_o & ~q_o
// The chain carries no reset so a reset never fabricates an edge
// on an input that is already high.
module sync_edge
    import audio_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic Clk,
    input  logic d_i,
    output logic q_o,
    output logic edge_o
);

    logic [STAGES-1:0] chain_q;
    logic              last_q;

    always_ff @(posedge Clk) begin
        chain_q <= {chain_q[STAGES-2:0], d_i};
        last_q  <= chain_q[STAGES-1];
    end

    assign q_o    = chain_q[STAGES-1];
    assign edge_o = chain_q[STAGES-1] ^ last_q;

endmodule

// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx: I2S ADC receiver. Oversamples BCLK/LRCK/DAT in the Clk
// domain, aligns to LRCK, deserialises SAMPLE_W bits MSB-first per channel
// and emits one signed stereo frame per LRCK period.
//   Clk          in   system clock
//   reset        in   synchronous, active-low reset
//   aud_bclk     in   codec bit clock (asynchronous, much slower than Clk)
//   aud_adclrck  in   codec LR clock, 0 = left half, 1 = right half
//   aud_adcdat   in   codec serial data
//   left_out     out  last committed left sample
//   right_out    out  last committed right sample
//   frame_valid  out  one-cycle strobe when left_out/right_out update
//   short_err    out  sticky flag: an LRCK edge arrived mid-word
// Build option: define MONO_MIX_EN to drive both outputs with the
// average (left + right) >>> 1 instead of the independent channels.
module i2s_adc_rx
    import audio_pkg::*;
#(
    parameter int SAMPLE_W    = AUDIO_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       Clk,
    input  logic                       reset,
    input  logic                       aud_bclk,
    input  logic                       aud_adclrck,
    input  logic                       aud_adcdat,
    output logic signed [SAMPLE_W-1:0] left_out,
    output logic signed [SAMPLE_W-1:0] right_out,
    output logic                       frame_valid,
    output logic                       short_err
);

    localparam int CNT_W = $clog2(SAMPLE_W + 1);

`ifdef MONO_MIX_EN
    // Sum at one extra bit so no overflow, then arithmetic halve.
    function automatic logic signed [SAMPLE_W-1:0] mono_mix(
        input logic signed [SAMPLE_W-1:0] a,
        input logic signed [SAMPLE_W-1:0] b
    );
        logic signed [SAMPLE_W:0] s;
        s = $signed({a[SAMPLE_W-1], a}) + $signed({b[SAMPLE_W-1], b});
        return s[SAMPLE_W:1];
    endfunction
`endif

    logic bclk_s, bclk_chg, lrck_s, lrck_chg, dat_s;
    logic [SYNC_STAGES-1:0] dat_sync_q;

    sync_edge #(.STAGES(SYNC_STAGES)) u_bclk_sync (
        .Clk    (Clk),
        .d_i    (aud_bclk),
        .q_o    (bclk_s),
        .edge_o (bclk_chg)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_lrck_sync (
        .Clk    (Clk),
        .d_i    (aud_adclrck),
        .q_o    (lrck_s),
        .edge_o (lrck_chg)
    );

    // Same depth as the sync_edge chains so DAT stays aligned with BCLK.
    always_ff @(posedge Clk) begin
        dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], aud_adcdat};
    end
    assign dat_s = dat_sync_q[SYNC_STAGES-1];

    rx_state_t                   state_q, state_d;
    logic [SAMPLE_W-1:0]         shreg_q, shreg_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [SAMPLE_W-1:0]  left_hold_q, left_hold_d;
    logic                        left_ok_q, left_ok_d;
    logic signed [SAMPLE_W-1:0]  left_out_q, left_out_d;
    logic signed [SAMPLE_W-1:0]  right_out_q, right_out_d;
    logic                        frame_valid_q, frame_valid_d;
    logic                        short_err_q, short_err_d;
    logic                        lrck_pend_q, lrck_pend_d;

    logic                        bclk_rise, lrck_edge;
    logic signed [SAMPLE_W-1:0]  word_new;

    assign bclk_rise = bclk_chg & bclk_s;
    // An LRCK change anywhere since the previous BCLK rise is credited to
    // this rise, including one that lands in the same Clk cycle.
    assign lrck_edge = bclk_rise & (lrck_pend_q | lrck_chg);
    assign word_new  = {shreg_q[SAMPLE_W-2:0], dat_s};

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        left_hold_d   = left_hold_q;
        left_ok_d     = left_ok_q;
        left_out_d    = left_out_q;
        right_out_d   = right_out_q;
        frame_valid_d = 1'b0;
        short_err_d   = short_err_q;
        lrck_pend_d   = bclk_rise ? 1'b0 : (lrck_pend_q | lrck_chg);

        if (bclk_rise) begin
            if (state_q == ALIGN) begin
                if (lrck_edge) begin
                    state_d   = SKIP;
                    left_ok_d = 1'b0;
                end
            end else if (lrck_edge) begin
                // New half starts: drop any partial word and re-align.
                if (state_q == SHIFT) short_err_d = 1'b1;
                state_d = SKIP;
                cnt_d   = '0;
                shreg_d = '0;
                // Entering a left half invalidates any stale left word.
                if (!lrck_s) left_ok_d = 1'b0;
            end else begin
                case (state_q)
                    SKIP: begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                        shreg_d = '0;
                    end
                    SHIFT: begin
                        shreg_d = word_new;
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(SAMPLE_W - 1)) begin
                            state_d = HOLD;
                            if (!lrck_s) begin
                                left_hold_d = word_new;
                                left_ok_d   = 1'b1;
                            end else if (left_ok_q) begin
`ifdef MONO_MIX_EN
                                left_out_d  = mono_mix(left_hold_q, word_new);
                                right_out_d = mono_mix(left_hold_q, word_new);
`else
                                left_out_d  = left_hold_q;
                                right_out_d = word_new;
`endif
                                frame_valid_d = 1'b1;
                                left_ok_d     = 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q       <= ALIGN;
            shreg_q       <= '0;
            cnt_q         <= '0;
            left_hold_q   <= '0;
            left_ok_q     <= 1'b0;
            left_out_q    <= '0;
            right_out_q   <= '0;
            frame_valid_q <= 1'b0;
            short_err_q   <= 1'b0;
            lrck_pend_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            left_hold_q   <= left_hold_d;
            left_ok_q     <= left_ok_d;
            left_out_q    <= left_out_d;
            right_out_q   <= right_out_d;
            frame_valid_q <= frame_valid_d;
            short_err_q   <= short_err_d;
            lrck_pend_q   <= lrck_pend_d;
        end
    end

    assign left_out    = left_out_q;
    assign right_out   = right_out_q;
    assign frame_valid = frame_valid_q;
    assign short_err   = short_err_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
module tb_i2s_adc_rx;

    logic               Clk = 1'b0;
    logic               reset;
    logic               aud_bclk, aud_adclrck, aud_adcdat;
    logic signed [15:0] left_out, right_out;
    logic               frame_valid, short_err;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int fv_cnt = 0;
    int consec = 0;
    int base;
    logic fv_prev = 1'b0;

    always #5 Clk = ~Clk;

    i2s_adc_rx dut (
        .Clk         (Clk),
        .reset       (reset),
        .aud_bclk    (aud_bclk),
        .aud_adclrck (aud_adclrck),
        .aud_adcdat  (aud_adcdat),
        .left_out    (left_out),
        .right_out   (right_out),
        .frame_valid (frame_valid),
        .short_err   (short_err)
    );

    // Count frame_valid pulses and back-to-back highs, sampled mid-cycle.
    always @(negedge Clk) begin
        if (frame_valid) fv_cnt++;
        if (frame_valid && fv_prev) consec++;
        fv_prev = frame_valid;
    end

`ifdef MONO_MIX_EN
    localparam logic [15:0] T2_L = 16'hDBFB, T2_R = 16'hDBFB;
    localparam logic [15:0] T3_L = 16'hFFFF, T3_R = 16'hFFFF;
    localparam logic [15:0] T4_L = 16'hFFFF, T4_R = 16'hFFFF;
    localparam logic [15:0] T5_L = 16'hD79B, T5_R = 16'hD79B;
    localparam logic [15:0] T6A_L = 16'h7FFF, T6A_R = 16'h7FFF;
    localparam logic [15:0] T6B_L = 16'hC000, T6B_R = 16'hC000;
`else
    localparam logic [15:0] T2_L = 16'h1234, T2_R = 16'hA5C3;
    localparam logic [15:0] T3_L = 16'h8000, T3_R = 16'h7FFF;
    localparam logic [15:0] T4_L = 16'h0F0F, T4_R = 16'hF0F0;
    localparam logic [15:0] T5_L = 16'h1357, T5_R = 16'h9BDF;
    localparam logic [15:0] T6A_L = 16'h7FFF, T6A_R = 16'h7FFF;
    localparam logic [15:0] T6B_L = 16'h8000, T6B_R = 16'h0001;
`endif

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One BCLK period: data/LRCK change while BCLK is low, sampled on the rise.
    task automatic send_bit(input logic lr, input logic d);
        aud_bclk    = 1'b0;
        aud_adclrck = lr;
        aud_adcdat  = d;
        #40;
        aud_bclk = 1'b1;
        #40;
    endtask

    // Bit slot i of a half: slot 0 carries the LRCK edge, slot 1 is the
    // I2S delay bit, slots 2..17 carry the word MSB first, rest padding.
    function automatic logic slot_bit(input logic [15:0] w, input int i);
        if (i >= 2 && i < 18) return w[17 - i];
        return 1'b0;
    endfunction

    task automatic send_half(input logic lr, input logic [15:0] w, input int nb);
        for (int i = 0; i < nb; i++) send_bit(lr, slot_bit(w, i));
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_half(1'b0, l, 32);
        send_half(1'b1, r, 32);
    endtask

    initial begin
        reset       = 1'b0;
        aud_bclk    = 1'b0;
        aud_adclrck = 1'b0;
        aud_adcdat  = 1'b0;

        // 1: reset held with toggling inputs
        repeat (10) begin
            @(negedge Clk);
            aud_bclk    = ~aud_bclk;
            aud_adclrck = ~aud_adclrck;
            aud_adcdat  = ~aud_adcdat;
        end
        check("rst_left", left_out, 16'h0000);
        check("rst_right", right_out, 16'h0000);
        check("rst_short", {15'd0, short_err}, 16'h0000);
        check("rst_fv_count", fv_cnt[15:0], 16'd0);
        @(negedge Clk);
        aud_bclk = 1'b0; aud_adclrck = 1'b0; aud_adcdat = 1'b0;
        repeat (6) @(negedge Clk);
        reset = 1'b1;
        repeat (6) @(negedge Clk);

        // 2: align on a right half (discarded), then one full frame
        base = fv_cnt;
        send_half(1'b1, 16'hFFFF, 32);
        check("t2_orphan_right", 16'(fv_cnt - base), 16'd0);
        send_frame(16'h1234, 16'hA5C3);
        check("t2_fv_count", 16'(fv_cnt - base), 16'd1);
        check("t2_left", left_out, T2_L);
        check("t2_right", right_out, T2_R);

        // 3: extremes, three back-to-back frames
        base = fv_cnt;
        for (int f = 0; f < 3; f++) begin
            send_frame(16'h8000, 16'h7FFF);
            check("t3_fv_count", 16'(fv_cnt - base), 16'(f + 1));
            check("t3_left", left_out, T3_L);
            check("t3_right", right_out, T3_R);
        end

        // 4: left word cut short after 10 data bits
        base = fv_cnt;
        send_half(1'b0, 16'h5555, 12);
        send_half(1'b1, 16'h1111, 32);
        check("t4_short_err", {15'd0, short_err}, 16'h0001);
        check("t4_no_frame", 16'(fv_cnt - base), 16'd0);
        check("t4_left_hold", left_out, T3_L);
        check("t4_right_hold", right_out, T3_R);
        send_frame(16'h0F0F, 16'hF0F0);
        check("t4_recover_fv", 16'(fv_cnt - base), 16'd1);
        check("t4_recover_left", left_out, T4_L);
        check("t4_recover_right", right_out, T4_R);
        check("t4_short_sticky", {15'd0, short_err}, 16'h0001);

        // 5: reset during the 8th bit of the right word
        send_half(1'b0, 16'h2468, 32);
        for (int i = 0; i < 9; i++) send_bit(1'b1, slot_bit(16'hABCD, i));
        aud_bclk    = 1'b0;
        aud_adclrck = 1'b1;
        aud_adcdat  = slot_bit(16'hABCD, 9);
        #20;
        reset = 1'b0;
        #20;
        aud_bclk = 1'b1;
        #20;
        reset = 1'b1;
        #20;
        base = fv_cnt;
        check("t5_left_zero", left_out, 16'h0000);
        check("t5_right_zero", right_out, 16'h0000);
        check("t5_short_clr", {15'd0, short_err}, 16'h0000);
        for (int i = 10; i < 32; i++) send_bit(1'b1, slot_bit(16'hABCD, i));
        send_half(1'b0, 16'h1357, 32);
        check("t5_no_frame_after_left", 16'(fv_cnt - base), 16'd0);
        send_half(1'b1, 16'h9BDF, 32);
        check("t5_fv_count", 16'(fv_cnt - base), 16'd1);
        check("t5_left", left_out, T5_L);
        check("t5_right", right_out, T5_R);

        // 6: mix corner values
        base = fv_cnt;
        send_frame(16'h7FFF, 16'h7FFF);
        check("t6a_left", left_out, T6A_L);
        check("t6a_right", right_out, T6A_R);
        send_frame(16'h8000, 16'h0001);
        check("t6b_left", left_out, T6B_L);
        check("t6b_right", right_out, T6B_R);
        check("t6_fv_count", 16'(fv_cnt - base), 16'd2);

        repeat (4) @(negedge Clk);
        check("fv_never_consecutive", 16'(consec), 16'd0);
        check("final_short_err", {15'd0, short_err}, 16'h0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
